// File: rtl/fastclkdiv_seq_if.sv
// Configuration channel for fastclkdiv_seq.
// Ports: cfg_valid/cfg_ready handshake, cfg_div, cfg_ntick, cfg_sync.
interface fastclkdiv_seq_if #(
    parameter int NBITS = 10,
    parameter int NCNT  = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [NBITS-1:0] cfg_div;
    logic [NCNT-1:0]  cfg_ntick;
    logic             cfg_sync;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_ntick,
        output cfg_sync,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_ntick,
        input  cfg_sync,
        output cfg_ready
    );
endinterface

// File: rtl/fastclkdiv_seq.sv
// Burst/continuous tick sequencer around a split-carry down-counter divider.
// Ports: i_clk, i_rst (sync, active high), cfg (config handshake),
//   i_trig, i_stop, o_tick, o_tick_count, o_busy, o_done.

module fastclkdiv #(
    parameter int NBITS       = 10,
    parameter int NBITS_STAGE = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_autoreload_en,
    input  logic [NBITS-1:0] i_load_q,
    output logic             o_zero
);
    localparam int NHI = NBITS - NBITS_STAGE;

    logic [NBITS_STAGE-1:0] lo_q, lo_d;
    logic [NHI-1:0]         hi_q, hi_d;
    logic                   lo_zero_q, hi_zero_q;

    // The count is split in two stages so the low stage never waits on a
    // full-width borrow; the stage zero flags are registered.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (i_load) begin
            {hi_d, lo_d} = i_load_q;
        end else if (i_en) begin
            if (lo_zero_q && hi_zero_q) begin
                if (i_autoreload_en) begin
                    {hi_d, lo_d} = i_load_q;
                end
            end else if (lo_zero_q) begin
                lo_d = '1;
                hi_d = hi_q - NHI'(1);
            end else begin
                lo_d = lo_q - NBITS_STAGE'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lo_q      <= '0;
            hi_q      <= '0;
            lo_zero_q <= 1'b1;
            hi_zero_q <= 1'b1;
        end else begin
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            lo_zero_q <= (lo_d == '0);
            hi_zero_q <= (hi_d == '0);
        end
    end

    assign o_zero = i_en & lo_zero_q & hi_zero_q;
endmodule

module fastclkdiv_seq #(
    parameter int NBITS       = 10,
    parameter int NBITS_STAGE = 9,
    parameter int NCNT        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fastclkdiv_seq_if.slave       cfg,
    input  logic                  i_trig,
    input  logic                  i_stop,
    output logic                  o_tick,
    output logic [NCNT-1:0]       o_tick_count,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ARM  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]       state_q;
    logic [NBITS-1:0] div_q;
    logic [NCNT-1:0]  ntick_q;
    logic [NCNT-1:0]  cnt_q;
    logic             sync_q;
    logic             done_q;
    logic             div_zero;
    logic             last_tick;

    fastclkdiv #(
        .NBITS       (NBITS),
        .NBITS_STAGE (NBITS_STAGE)
    ) u_div (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_en            (state_q == S_RUN),
        .i_load          (state_q == S_LOAD),
        .i_autoreload_en (state_q == S_RUN),
        .i_load_q        (div_q),
        .o_zero          (div_zero)
    );

    // Tick that brings the count up to ntick ends a bounded run.
    assign last_tick = (ntick_q != '0) && (cnt_q == ntick_q - NCNT'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            ntick_q <= '0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg.cfg_valid) begin
                        div_q   <= cfg.cfg_div;
                        ntick_q <= cfg.cfg_ntick;
                        sync_q  <= cfg.cfg_sync;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= sync_q ? S_ARM : S_RUN;
                end
                S_ARM: begin
                    if (i_stop) begin
                        state_q <= S_IDLE;
                    end else if (i_trig) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (div_zero) begin
                        cnt_q <= cnt_q + NCNT'(1);
                    end
                    if (i_stop) begin
                        state_q <= S_IDLE;
                    end else if (div_zero && last_tick) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Everything is held low while reset is asserted.
    assign cfg.cfg_ready = (state_q == S_IDLE) & ~i_rst;
    assign o_busy        = (state_q != S_IDLE) & ~i_rst;
    assign o_tick        = div_zero & ~i_rst;
    assign o_done        = done_q & ~i_rst;
    assign o_tick_count  = i_rst ? '0 : cnt_q;
endmodule

// File: tb/tb_fastclkdiv_seq.sv
// Testbench for fastclkdiv_seq: directed table, reset corners and random
// runs checked cycle by cycle against a tick-schedule model.
module tb_fastclkdiv_seq;
    localparam int NB = 6;
    localparam int NS = 3;
    localparam int NC = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_trig = 1'b0;
    logic          i_stop = 1'b0;
    logic          o_tick, o_busy, o_done;
    logic [NC-1:0] o_tick_count;

    fastclkdiv_seq_if #(.NBITS(NB), .NCNT(NC)) cfg ();

    fastclkdiv_seq #(
        .NBITS       (NB),
        .NBITS_STAGE (NS),
        .NCNT        (NC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cfg          (cfg.slave),
        .i_trig       (i_trig),
        .i_stop       (i_stop),
        .o_tick       (o_tick),
        .o_tick_count (o_tick_count),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int d;
        int n;
        bit sync;
        int toff;
        int stopk;
        int exp_cnt;
        bit exp_done;
    } vec_t;

    // Tick k (1-based) of a run that entered RUN at cycle r.
    function automatic int tick_at(input int r, input int d, input int k);
        return r + d + (k - 1) * (d + 1);
    endfunction

    function automatic bit is_tick(input int c, input int r, input int e,
                                   input int d);
        if (c < r + d || c >= e) return 1'b0;
        return ((c - r - d) % (d + 1)) == 0;
    endfunction

    // Ticks emitted strictly before cycle c, modulo the counter width.
    function automatic int ntk(input int c, input int r, input int e,
                               input int d);
        int m;
        m = ((c < e) ? c : e) - 1;
        if (m < r + d) return 0;
        return ((m - r - d) / (d + 1) + 1) % (1 << NC);
    endfunction

    task automatic run_one(input int d, input int n, input bit sync,
                           input int toff, input int stopk,
                           output int fcnt, output bit fdone);
        int t, r, a, e, s, w;
        bit normal;
        fcnt  = -1;
        fdone = 1'b0;
        w     = 0;
        @(negedge i_clk);
        while (cfg.cfg_ready !== 1'b1 && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        chk("ready_wait", int'(cfg.cfg_ready), 1);
        t = cyc;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = NB'(d);
        cfg.cfg_ntick = NC'(n);
        cfg.cfg_sync  = sync;
        i_trig        = 1'b1;
        i_stop        = 1'b0;
        a = t + 2 + toff;
        r = sync ? a + 1 : t + 2;
        if (sync && stopk == 0) begin
            s = a;
            e = a + 1;
            normal = 1'b0;
        end else if (stopk > 0) begin
            s = tick_at(r, d, stopk);
            e = s + 1;
            normal = 1'b0;
        end else begin
            s = -1;
            e = tick_at(r, d, n) + 1;
            normal = 1'b1;
        end
        for (int c = t + 1; c <= e + 2; c++) begin
            @(negedge i_clk);
            chk("tick", int'(o_tick), int'(is_tick(c, r, e, d)));
            chk("count", int'(o_tick_count), ntk(c, r, e, d));
            chk("busy", int'(o_busy), int'(c < e));
            chk("ready", int'(cfg.cfg_ready), int'(c >= e));
            chk("done", int'(o_done), int'(normal && c == e));
            if (c == e) begin
                fcnt  = int'(o_tick_count);
                fdone = o_done;
            end
            cfg.cfg_valid = (c < e) && ($urandom_range(0, 2) == 0);
            cfg.cfg_div   = NB'($urandom);
            cfg.cfg_ntick = NC'($urandom);
            cfg.cfg_sync  = 1'($urandom);
            if (sync) i_trig = (c == t + 1) || (c == a);
            else      i_trig = 1'($urandom);
            i_stop = (c == s) ||
                     ((c == t + 1 || c > e) && $urandom_range(0, 1) == 1);
        end
        cfg.cfg_valid = 1'b0;
        i_trig = 1'b0;
        i_stop = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        int fc, t;
        bit fd;
        tbl[0] = '{3, 4, 1'b0, 0, -1, 4, 1'b1};
        tbl[1] = '{0, 3, 1'b0, 0, -1, 3, 1'b1};
        tbl[2] = '{2, 2, 1'b1, 3, -1, 2, 1'b1};
        tbl[3] = '{4, 10, 1'b0, 0, 3, 3, 1'b0};
        tbl[4] = '{9, 2, 1'b0, 0, -1, 2, 1'b1};
        tbl[5] = '{1, 0, 1'b0, 0, 20, 4, 1'b0};
        tbl[6] = '{1, 15, 1'b0, 0, -1, 15, 1'b1};
        tbl[7] = '{5, 1, 1'b1, 1, -1, 1, 1'b1};
        tbl[8] = '{3, 2, 1'b1, 2, 0, 0, 1'b0};
        tbl[9] = '{0, 0, 1'b0, 0, 18, 2, 1'b0};

        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        cfg.cfg_ntick = '0;
        cfg.cfg_sync  = 1'b0;

        repeat (3) @(negedge i_clk);
        chk("rst_ready", int'(cfg.cfg_ready), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_count", int'(o_tick_count), 0);
        chk("rst_done", int'(o_done), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", int'(cfg.cfg_ready), 1);
        chk("post_rst_tick", int'(o_tick), 0);

        foreach (tbl[i]) begin
            run_one(tbl[i].d, tbl[i].n, tbl[i].sync, tbl[i].toff,
                    tbl[i].stopk, fc, fd);
            chk("tbl_count", fc, tbl[i].exp_cnt);
            chk("tbl_done", int'(fd), int'(tbl[i].exp_done));
        end

        // Reset in the middle of a continuous run, between ticks.
        @(negedge i_clk);
        t = cyc;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = NB'(3);
        cfg.cfg_ntick = '0;
        cfg.cfg_sync  = 1'b0;
        @(negedge i_clk);
        cfg.cfg_valid = 1'b0;
        while (cyc < t + 7) @(negedge i_clk);
        chk("mid_busy", int'(o_busy), 1);
        chk("mid_count", int'(o_tick_count), 1);
        i_rst = 1'b1;
        #1;
        chk("in_rst_ready", int'(cfg.cfg_ready), 0);
        chk("in_rst_busy", int'(o_busy), 0);
        chk("in_rst_count", int'(o_tick_count), 0);
        chk("in_rst_tick", int'(o_tick), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("after_rst_ready", int'(cfg.cfg_ready), 1);
        repeat (10) begin
            @(negedge i_clk);
            chk("after_rst_tick", int'(o_tick), 0);
            chk("after_rst_busy", int'(o_busy), 0);
            chk("after_rst_done", int'(o_done), 0);
            chk("after_rst_count", int'(o_tick_count), 0);
        end

        for (int k = 0; k < 25; k++) begin
            int d, n, toff, stopk;
            bit sync;
            d     = $urandom_range(0, 20);
            n     = $urandom_range(0, 6);
            sync  = 1'($urandom_range(0, 1));
            toff  = $urandom_range(1, 4);
            stopk = -1;
            if (n == 0) stopk = $urandom_range(1, 20);
            else if (n > 1 && $urandom_range(0, 2) == 0)
                stopk = $urandom_range(1, n - 1);
            if (sync && $urandom_range(0, 5) == 0) stopk = 0;
            run_one(d, n, sync, toff, stopk, fc, fd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
